// File: rtl/mux_4x1.sv
// Four-input data multiplexer with an optional registered output stage.
// OUT_REG=1 gives one cycle of latency and a y_valid strobe; OUT_REG=0 is pure combinational.
module mux_4x1 #(
  parameter int WIDTH   = 1,
  parameter bit OUT_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] y,
  output logic             y_valid
);

  if (WIDTH < 1) begin : g_width_check
    $error("mux_4x1: WIDTH must be at least 1");
  end

  logic [WIDTH-1:0] m;

  // An X/Z select lands in the default arm so the unknown shows up on m.
  always_comb begin
    m = {WIDTH{1'bx}};
    case (sel)
      2'd0:    m = d0;
      2'd1:    m = d1;
      2'd2:    m = d2;
      2'd3:    m = d3;
      default: m = {WIDTH{1'bx}};
    endcase
  end

  if (OUT_REG) begin : g_reg
    logic [WIDTH-1:0] y_q, y_d;
    logic             y_valid_q, y_valid_d;

    always_comb begin
      y_d       = en ? m : y_q;
      y_valid_d = en;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        y_q       <= '0;
        y_valid_q <= 1'b0;
      end else begin
        y_q       <= y_d;
        y_valid_q <= y_valid_d;
      end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
  end else begin : g_comb
    logic unused_sink;
    assign unused_sink = &{1'b0, clk, rst, en};
    assign y           = m;
    assign y_valid     = 1'b1;
  end

endmodule

// File: tb/tb_mux_4x1.sv
// Directed bench for mux_4x1: a registered 1-bit instance and a combinational 8-bit instance.
module tb_mux_4x1;

  int n_cmp = 0;
  int n_err = 0;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [1:0] sel;
  logic       d0, d1, d2, d3;
  logic       y_r, yv_r;

  logic       rst_c, en_c;
  logic [1:0] sel_c;
  logic [7:0] c0, c1, c2, c3;
  logic [7:0] y_c;
  logic       yv_c;

  always #5 clk = ~clk;

  mux_4x1 #(.WIDTH(1), .OUT_REG(1'b1)) u_reg (
    .clk(clk), .rst(rst), .en(en), .sel(sel),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .y(y_r), .y_valid(yv_r)
  );

  mux_4x1 #(.WIDTH(8), .OUT_REG(1'b0)) u_comb (
    .clk(clk), .rst(rst_c), .en(en_c), .sel(sel_c),
    .d0(c0), .d1(c1), .d2(c2), .d3(c3),
    .y(y_c), .y_valid(yv_c)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       exp_bit;
    logic [3:0] dv;
    logic [3:0] sweep_exp;

    rst = 1'b1; en = 1'b1; sel = 2'd2;
    d0 = 1'b1; d1 = 1'b1; d2 = 1'b1; d3 = 1'b1;
    rst_c = 1'b0; en_c = 1'b1; sel_c = 2'd0;
    c0 = 8'h11; c1 = 8'h22; c2 = 8'h33; c3 = 8'h44;

    // Reset holds y low even with en=1.
    edge_sample();
    check("rst1_y", {7'd0, y_r}, 8'h00);
    check("rst1_v", {7'd0, yv_r}, 8'h00);
    edge_sample();
    check("rst2_y", {7'd0, y_r}, 8'h00);
    check("rst2_v", {7'd0, yv_r}, 8'h00);
    rst = 1'b0;
    #3;
    check("rst_rel_noedge", {7'd0, y_r}, 8'h00);
    edge_sample();
    check("post_rst_y", {7'd0, y_r}, 8'h01);
    check("post_rst_v", {7'd0, yv_r}, 8'h01);

    // Select sweep.
    d0 = 1'b0; d1 = 1'b1; d2 = 1'b0; d3 = 1'b1;
    sweep_exp = 4'b1010;
    for (int s = 0; s < 4; s++) begin
      sel = s[1:0];
      edge_sample();
      check($sformatf("sweep_sel%0d", s), {7'd0, y_r}, {7'd0, sweep_exp[s]});
      check($sformatf("sweep_v%0d", s), {7'd0, yv_r}, 8'h01);
    end

    // Between-edge changes must not reach y.
    sel = 2'd0;
    #2;
    check("between_edges", {7'd0, y_r}, 8'h01);

    // Hold with en=0.
    sel = 2'd1; d1 = 1'b1;
    edge_sample();
    check("hold_load", {7'd0, y_r}, 8'h01);
    en = 1'b0; sel = 2'd0; d0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      edge_sample();
      check($sformatf("hold_y%0d", k), {7'd0, y_r}, 8'h01);
      check($sformatf("hold_v%0d", k), {7'd0, yv_r}, 8'h00);
    end
    en = 1'b1;
    edge_sample();
    check("hold_release_y", {7'd0, y_r}, 8'h00);
    check("hold_release_v", {7'd0, yv_r}, 8'h01);

    // Random stream against a one-deep scoreboard.
    for (int k = 0; k < 16; k++) begin
      dv  = 4'($urandom_range(0, 15));
      sel = 2'($urandom_range(0, 3));
      d0 = dv[0]; d1 = dv[1]; d2 = dv[2]; d3 = dv[3];
      exp_bit = dv[sel];
      edge_sample();
      check($sformatf("rand%0d", k), {7'd0, y_r}, {7'd0, exp_bit});
    end

    // Reset in the middle of a stream.
    sel = 2'd3; d3 = 1'b1;
    edge_sample();
    check("mid_pre", {7'd0, y_r}, 8'h01);
    rst = 1'b1;
    edge_sample();
    check("mid_rst_y", {7'd0, y_r}, 8'h00);
    check("mid_rst_v", {7'd0, yv_r}, 8'h00);
    rst = 1'b0;
    edge_sample();
    check("mid_after_y", {7'd0, y_r}, 8'h01);
    check("mid_after_v", {7'd0, yv_r}, 8'h01);

    // Combinational instance: zero latency, clock/reset/en have no effect.
    #2;
    sel_c = 2'd3;
    #1;
    check("comb_sel3", y_c, 8'h44);
    sel_c = 2'd0;
    #1;
    check("comb_sel0", y_c, 8'h11);
    rst_c = 1'b1; en_c = 1'b0;
    #1;
    check("comb_rst", y_c, 8'h11);
    edge_sample();
    check("comb_rst_edge", y_c, 8'h11);
    check("comb_valid", {7'd0, yv_c}, 8'h01);
    sel_c = 2'd1;
    #1;
    check("comb_sel1", y_c, 8'h22);
    sel_c = 2'd2;
    #1;
    check("comb_sel2", y_c, 8'h33);
    c2 = 8'hA5;
    #1;
    check("comb_data_chg", y_c, 8'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_4x1.md
Name: mux_4x1

Overview:
- Four-input, one-output data multiplexer; `sel` chooses which of `d0..d3` drives `y`.
- Used as a generic selection primitive in datapaths.
- Output stage is registered by default, with an optional combinational bypass.
- Data width is parameterized; the default is 1 bit.

Parameters:
- WIDTH, 1, bit width of each data input and of `y`.
- OUT_REG, 1, 1 = `y` registered (1-cycle latency); 0 = `y` purely combinational from `sel`/`d*`.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  capture enable for the output register; ignored when OUT_REG=0.
- sel  input  2  select: 0→d0, 1→d1, 2→d2, 3→d3.
- d0  input  WIDTH  data input 0.
- d1  input  WIDTH  data input 1.
- d2  input  WIDTH  data input 2.
- d3  input  WIDTH  data input 3.
- y  output  WIDTH  selected data.
- y_valid  output  1  high when `y` holds a value captured on the previous enabled cycle.

Behaviour:
- Combinational select `m = d[sel]`:
  - Full decode of all four `sel` codes; no default/latch path.
  - `sel` containing X/Z propagates X to `m` in simulation; no X masking.
- OUT_REG=1:
  - Rising clk with rst=1: `y` <= 0, `y_valid` <= 0. rst has priority over `en`.
  - Rising clk with rst=0, en=1: `y` <= `m`, `y_valid` <= 1.
  - Rising clk with rst=0, en=0: `y` holds, `y_valid` <= 0.
  - Latency: `sel`/`d*` sampled at edge N appear on `y` after edge N; `y` never changes between edges.
  - `sel` or data changing between edges has no effect until the next enabled edge.
  - Reset asserted mid-stream clears `y` on that same edge; the first enabled edge after rst deasserts loads fresh data.
- OUT_REG=0:
  - `y` = `m` at all times, zero latency; clk, rst and `en` do not affect `y`.
  - `y_valid` tied to 1.
- Width rules:
  - All data paths are exactly WIDTH bits; no extension or truncation.
  - WIDTH ≥ 1 is required. The implementation raises an elaboration error for WIDTH < 1.
- No internal state other than the `y` and `y_valid` registers.

Test Plan:
- Reset, OUT_REG=1, WIDTH=1: rst=1 for 2 cycles with d0..d3=1, sel=2, en=1 → `y`=0, `y_valid`=0. First edge after rst=0 → `y`=1, `y_valid`=1.
- Exhaustive select, OUT_REG=1, en=1: d0=0, d1=1, d2=0, d3=1; sweep sel 0,1,2,3 on consecutive edges → `y` = 0,1,0,1, each one cycle after its sel.
- Hold with en=0: load sel=1, d1=1 (`y`=1). Then set en=0, sel=0, d0=0 for 3 cycles → `y` stays 1, `y_valid`=0. en=1 again → `y`=0 next edge.
- Combinational mode, OUT_REG=0, WIDTH=8: d0=0x11, d1=0x22, d2=0x33, d3=0x44; sel=3 → `y`=0x44 immediately. sel=0 → `y`=0x11 with no clock edge. rst=1 leaves `y` unchanged.
- Random stimulus, OUT_REG=1: 10 or more cycles of random sel (0–3) and random 1-bit d0..d3 with en=1. A scoreboard compares `y` each cycle against `d[sel]` sampled on the previous edge → zero mismatches.
- Reset mid-operation: while streaming sel=3, d3=1, assert rst for one edge → `y`=0 on that edge; next edge with rst=0 → `y`=1.
